i2c_bus_arbiter: RTL
====================

# i2c_bus_arbiter

Round-robin arbiter and sequencer that shares a single `i2c_master` between `NUM_REQ` on-chip requesters. It generates the master's `tick_4x` bit-rate strobe and latches the granted requester's command onto the master's inputs. It holds `enable` for exactly one transaction, then returns a per-requester completion pulse. A tick watchdog flags transactions that never finish.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `CLK_DIV`, default 250: clk cycles per `tick_4x` pulse; must be ≥ 2.
- `TIMEOUT_TICKS`, default 256: `tick_4x` pulses allowed in RUN before abort; must be ≥ 128.

Ports:
- `clk  in  1`: system clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `req  in  NUM_REQ`: level request, one bit per requester.
- `req_addr  in  NUM_REQ*7`: 7-bit slave address per requester; requester i uses bits [7i+6:7i].
- `req_rw  in  NUM_REQ`: rw bit per requester.
- `req_data  in  NUM_REQ*12`: 12-bit write data per requester; requester i uses bits [12i+11:12i].
- `gnt  out  NUM_REQ`: one-hot grant, high from GRANT through DONE.
- `cmpl  out  NUM_REQ`: one-cycle completion pulse to the served requester.
- `cmpl_err  out  1`: qualifies `cmpl`; 1 means watchdog timeout.
- `busy  out  1`: state ≠ IDLE.
- `tick_4x  out  1`: one-clk strobe every `CLK_DIV` clks, to the master.
- `m_enable  out  1`: master enable.
- `m_rw  out  1`: latched rw, to the master.
- `m_slave_addr  out  7`: latched address, to the master.
- `m_data_in  out  12`: latched data, to the master.
- `m_done  in  1`: master done.

## Operation
- Tick generator: free-running counter 0..`CLK_DIV`-1. `tick_4x`=1 only when the counter equals `CLK_DIV`-1. It runs in every state.
- The FSM uses `arb_state_t` and has four states: IDLE, GRANT, RUN, DONE.
- **IDLE**:
  - If `req` ≠ 0, select the first set bit at or after `rr_ptr`, wrapping around.
  - Register the winner index and load its addr/rw/data into the `m_*` registers.
  - Go to GRANT.
- **GRANT**: `gnt[winner]`=1. Clear the watchdog. Go to RUN.
- **RUN**:
  - `m_enable`=1.
  - The watchdog increments on each `tick_4x`.
  - On a rising edge of `m_done` (`m_done` & !`done_q`), go to DONE with err=0.
  - Else, when the watchdog reaches `TIMEOUT_TICKS`, go to DONE with err=1.
- **DONE**:
  - `cmpl[winner]`=1 for one cycle, with `cmpl_err`=err.
  - `rr_ptr` ← winner+1, modulo `NUM_REQ`.
  - Go to IDLE.
- `m_enable` is decoded from the registered state, so it is glitch-free. It is low in every state except RUN.
- `m_done` is high for a whole tick period, and `CLK_DIV`≥2 guarantees `m_enable` is low before the master returns to IDLE. No double transaction occurs.
- `m_rw`, `m_slave_addr` and `m_data_in` change only on the IDLE→GRANT edge and hold through DONE.
- `req`/command changes after GRANT are ignored. A requester deasserting `req` mid-transaction still receives `cmpl`.
- A requester that holds `req` high in the cycle after `cmpl` is treated as a new request. Round-robin places it last among the active requesters.
- A NACK from the slave still ends with `m_done`. This is reported as err=0; the arbiter does not detect NACK.
- Timeout with the master still mid-frame: the arbiter returns to IDLE anyway. Software must reset the I2C subsystem. The next grant is not blocked.

## Timing
- Reset values:
  - state=IDLE, `rr_ptr`=0, tick counter=0, watchdog=0, `done_q`=0.
  - All outputs 0: `gnt`, `cmpl`, `cmpl_err`, `busy`, `tick_4x`, `m_enable`, `m_rw`, `m_slave_addr`, `m_data_in`.
- Latency:
  - `req` sampled high at edge t → `gnt` high from t+1 → `m_enable` high from t+2.
  - `m_done` rise sampled at edge d → `cmpl` high in cycle d+1 → `busy` low at d+2.
- Minimum gap between transactions: 1 IDLE cycle.
- Simultaneous requests: exactly one grant, chosen by `rr_ptr`. Timeout and `m_done` rise in the same cycle: `m_done` wins, err=0.
- Reset mid-operation: asserting `rst_n` low at any time immediately returns all state and outputs to their reset values; no `cmpl` is issued.

## Structure
- Add `arb_state_t` (IDLE, GRANT, RUN, DONE) to the shared package `i2c_pkg`, alongside the master's `state_t`.
- Sub-module `i2c_tick_gen` (parameter `CLK_DIV`; ports `clk`, `rst_n`, `tick`) contains the divider. It is reusable by other I2C blocks.
- Round-robin selection is one combinational function in the arbiter.

## Test plan
- Single request: `req`=0001, addr 0x50, rw 0, data 0xABC, ACKing slave model → `m_enable` at t+2; exactly one START..STOP frame; `cmpl`=0001 with err=0; `busy` falls.
- Contention: `req`=1111 held continuously → grant order 0,1,2,3,0; each `cmpl` one cycle; never two `gnt` bits high.
- Command stability: change `req_data[0]` to 0x123 during RUN → bus still carries 0xABC.
- Timeout: `m_done` tied 0, `TIMEOUT_TICKS`=128 → `cmpl` with `cmpl_err`=1 exactly one cycle after the 128th tick in RUN.
- NACK: slave never ACKs address → master STOPs early; `cmpl` err=0; next requester is served.
- Reset mid-RUN: `rst_n` low for 3 cycles → all outputs 0 and `rr_ptr`=0; after release, `req`=0100 is granted normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C type definitions: the master's bit-level states and the
// requester arbiter's transaction states.
package i2c_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RUN,
        DONE
    } arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Command/strobe bundle between the requester arbiter (master modport)
// and the shared i2c_master core (slave modport).
interface i2c_bus_arbiter_if;
    import i2c_pkg::*;

    logic              tick_4x;
    logic              m_enable;
    logic              m_rw;
    logic [ADDR_W-1:0] m_slave_addr;
    logic [DATA_W-1:0] m_data_in;
    logic              m_done;

    modport master (
        output tick_4x,
        output m_enable,
        output m_rw,
        output m_slave_addr,
        output m_data_in,
        input  m_done
    );

    modport slave (
        input  tick_4x,
        input  m_enable,
        input  m_rw,
        input  m_slave_addr,
        input  m_data_in,
        output m_done
    );

endinterface

// File: rtl/i2c_tick_gen.sv
// Free-running divider producing a one-clk strobe every CLK_DIV clocks;
// shared by I2C blocks that need the 4x bit-rate tick.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NUM_REQ requesters,
// latching the winner's command and guarding each transaction with a tick watchdog.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned CLK_DIV       = 250,
    parameter int unsigned TIMEOUT_TICKS = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        cmpl,
    output logic                      cmpl_err,
    output logic                      busy,
    i2c_bus_arbiter_if.master         bus
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);
    localparam int unsigned WDW  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
    localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT_TICKS);

    arb_state_t        state;
    logic [IDXW-1:0]   winner;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   pick;
    logic [WDW-1:0]    wd;
    logic [WDW-1:0]    wd_inc;
    logic              done_q;
    logic              done_rise;
    logic              timeout;
    logic              tick;
    logic              m_rw;
    logic [ADDR_W-1:0] m_slave_addr;
    logic [DATA_W-1:0] m_data_in;

    // First requester at or after ptr, wrapping; returns ptr when nobody asks.
    function automatic logic [IDXW-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDXW-1:0]    ptr
    );
        logic [IDXW-1:0] win;
        logic            found;
        int unsigned     idx;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && r[idx]) begin
                win   = IDXW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign pick      = rr_pick(req, rr_ptr);
    assign wd_inc    = wd + WDW'(tick);
    assign timeout   = tick && (wd_inc == WD_LIMIT);
    assign done_rise = bus.m_done && !done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            winner       <= '0;
            rr_ptr       <= '0;
            wd           <= '0;
            done_q       <= 1'b0;
            gnt          <= '0;
            cmpl         <= '0;
            cmpl_err     <= 1'b0;
            m_rw         <= 1'b0;
            m_slave_addr <= '0;
            m_data_in    <= '0;
        end else begin
            done_q <= bus.m_done;
            case (state)
                IDLE: begin
                    if (|req) begin
                        winner       <= pick;
                        gnt          <= NUM_REQ'(1) << pick;
                        m_rw         <= req_rw[pick];
                        m_slave_addr <= req_addr[32'(pick)*ADDR_W +: ADDR_W];
                        m_data_in    <= req_data[32'(pick)*DATA_W +: DATA_W];
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: begin
                    wd <= wd_inc;
                    // A done edge coinciding with the final tick still counts as success.
                    if (done_rise) begin
                        cmpl     <= gnt;
                        cmpl_err <= 1'b0;
                        state    <= DONE;
                    end else if (timeout) begin
                        cmpl     <= gnt;
                        cmpl_err <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cmpl     <= '0;
                    cmpl_err <= 1'b0;
                    gnt      <= '0;
                    rr_ptr   <= (winner == LAST_IDX) ? '0 : winner + IDXW'(1);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign bus.m_enable     = (state == RUN);
    assign bus.tick_4x      = tick;
    assign bus.m_rw         = m_rw;
    assign bus.m_slave_addr = m_slave_addr;
    assign bus.m_data_in    = m_data_in;

endmodule
